// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit hex 7-segment display driver.
// A prescaler sets the length of each digit slot, and an index selects one digit per slot.
// New values are double-buffered so they only take effect when the index wraps.
// The output stage is registered. It applies leading-zero blanking and output polarity.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 50000,
    parameter bit ACTIVE_LOW_SEG = 1'b0,
    parameter bit ACTIVE_LOW_AN  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(PRESCALE);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);

    // XOR masks. Each one is also the "off" level of its output in that polarity.
    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW_SEG}};
    localparam logic                  DP_OFF  = ACTIVE_LOW_SEG;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW_AN}};

    // Standard hex glyph set, bit6=g .. bit0=a, active-high.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    logic [CNT_W-1:0]                cnt;
    logic [IDX_W-1:0]                idx;
    logic [NUM_DIGITS-1:0][3:0]      active_val;
    logic [NUM_DIGITS-1:0]           active_dp;
    logic [NUM_DIGITS-1:0][3:0]      shadow_val;
    logic [NUM_DIGITS-1:0]           shadow_dp;
    logic                            pending;

    logic                            tick;
    logic                            wrap;
    logic [NUM_DIGITS-1:0]           lz_mask;
    logic                            lz_run;
    logic [6:0]                      cur_seg;
    logic                            cur_dp;
    logic [NUM_DIGITS-1:0]           cur_an;

    // A tick ends a digit slot. A wrap is a tick on the last digit, which closes the frame.
    assign tick = enable && (cnt == LAST_CNT);
    assign wrap = tick && (idx == LAST_IDX);

    // Slot prescaler. It only advances while scanning is enabled, so a pause keeps the slot position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + CNT_W'(1);
    end

    // Digit index. It steps once per slot and wraps after the most significant digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx <= '0;
        else if (tick)
            idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end

    // Double buffer. A load is held in the shadow regs and moves to the active regs only on a
    // wrap. A load in the wrap cycle itself goes straight to the active regs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_val <= '0;
            active_dp  <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end
            if (wrap) begin
                if (load) begin
                    active_val <= value;
                    active_dp  <= dp_in;
                end else if (pending) begin
                    active_val <= shadow_val;
                    active_dp  <= shadow_dp;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Frame pulse. It is set in the cycle after the wrap, which is also when a new value goes live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_done <= 1'b0;
        else
            frame_done <= wrap;
    end

    // Leading-zero mask. A digit is blanked when it and every more significant digit are zero.
    // Digit 0 is never blanked. blank_lz is used live, not latched.
    always_comb begin
        lz_run  = blank_lz;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run && (active_val[i] == 4'd0);
            lz_mask[i] = lz_run && (i != 0);
        end
    end

    // Active-high view of the selected digit, before the output register.
    always_comb begin
        cur_an      = '0;
        cur_an[idx] = 1'b1;
        cur_dp      = active_dp[idx];
        cur_seg     = lz_mask[idx] ? 7'h00 : glyph(active_val[idx]);
    end

    // Registered outputs with polarity applied. The display is dark in reset and while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= AN_OFF;
        end else if (!enable) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= cur_seg ^ SEG_OFF;
            dp  <= cur_dp ^ DP_OFF;
            an  <= cur_an ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: two instances share all inputs. One is active-high and the other is
// active-low on both seg and an. A behavioural model gives the expected outputs each cycle.
// Directed scenarios pin exact glyph and timing values.
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int P = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [6:0]  seg,   seg_n;
    logic        dp,    dp_n;
    logic [3:0]  an,    an_n;
    logic        fd,    fd_n;

    int n_checks = 0;
    int n_errors = 0;
    bit mdl_en   = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_AN(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_done(fd));

    seg7_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)) dut_n (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_n), .dp(dp_n), .an(an_n), .frame_done(fd_n));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt, m_idx;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_adp, m_sdp;
    logic        m_pend;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd;
    logic [3:0]  exp_an;

    logic [3:0]  cur_nib;
    logic        cur_hi_zero;
    logic        m_wrap;
    logic [6:0]  exp_seg_n;
    logic        exp_dp_n;
    logic [3:0]  exp_an_n;

    assign cur_nib     = 4'((m_act >> (4 * m_idx)) & 16'hF);
    assign cur_hi_zero = ((m_act >> (4 * m_idx)) == 16'h0);
    assign m_wrap      = enable && (m_cnt == P - 1) && (m_idx == N - 1);
    assign exp_seg_n   = ~exp_seg;
    assign exp_dp_n    = ~exp_dp;
    assign exp_an_n    = ~exp_an;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt <= 0; m_idx <= 0; m_act <= '0; m_adp <= '0; m_sh <= '0; m_sdp <= '0;
            m_pend <= 1'b0; exp_seg <= '0; exp_dp <= 1'b0; exp_an <= '0; exp_fd <= 1'b0;
        end else begin
            if (!enable) begin
                exp_seg <= '0; exp_dp <= 1'b0; exp_an <= '0;
            end else begin
                exp_seg <= (blank_lz && m_idx > 0 && cur_hi_zero) ? 7'h00 : GLYPH[cur_nib];
                exp_dp  <= m_adp[m_idx];
                exp_an  <= 4'(1 << m_idx);
            end
            exp_fd <= m_wrap;
            if (enable) begin
                if (m_cnt == P - 1) begin
                    m_cnt <= 0;
                    m_idx <= (m_idx + 1) % N;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
            if (m_wrap) begin
                if (load) begin
                    m_act <= value; m_adp <= dp_in;
                end else if (m_pend) begin
                    m_act <= m_sh; m_adp <= m_sdp;
                end
                m_pend <= 1'b0;
            end else if (load) begin
                m_pend <= 1'b1;
            end
            if (load) begin
                m_sh <= value; m_sdp <= dp_in;
            end
        end
    end

    // Compare every cycle against the model, on the falling edge.
    always @(negedge clk) begin
        if (mdl_en) begin
            chk("mdl_seg",   32'(seg),   32'(exp_seg));
            chk("mdl_dp",    32'(dp),    32'(exp_dp));
            chk("mdl_an",    32'(an),    32'(exp_an));
            chk("mdl_fd",    32'(fd),    32'(exp_fd));
            chk("mdl_seg_n", 32'(seg_n), 32'(exp_seg_n));
            chk("mdl_dp_n",  32'(dp_n),  32'(exp_dp_n));
            chk("mdl_an_n",  32'(an_n),  32'(exp_an_n));
            chk("mdl_fd_n",  32'(fd_n),  32'(exp_fd));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_fd();
        bit found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (fd) found = 1'b1;
        end
        chk("frame_done_seen", 32'(found), 32'd1);
    endtask

    // Wait for a frame boundary, then check the first cycle of each of the four digit slots.
    task automatic check_frame(input logic [6:0] g0, input logic [6:0] g1,
                               input logic [6:0] g2, input logic [6:0] g3,
                               input logic [3:0] dpm);
        logic [6:0] g [4];
        logic [3:0] oh;
        logic [3:0] ohn;
        logic [6:0] gn;
        g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
        wait_fd();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) @(negedge clk);
            else repeat (P) @(negedge clk);
            oh  = 4'(1 << i);
            ohn = ~oh;
            gn  = ~g[i];
            chk("lit_an",    32'(an),    32'(oh));
            chk("lit_seg",   32'(seg),   32'(g[i]));
            chk("lit_dp",    32'(dp),    32'(dpm[i]));
            chk("lit_an_n",  32'(an_n),  32'(ohn));
            chk("lit_seg_n", 32'(seg_n), 32'(gn));
        end
    endtask

    task automatic check_reset_levels();
        chk("rst_seg",   32'(seg),   32'h00);
        chk("rst_dp",    32'(dp),    32'd0);
        chk("rst_an",    32'(an),    32'h0);
        chk("rst_fd",    32'(fd),    32'd0);
        chk("rst_seg_n", 32'(seg_n), 32'h7F);
        chk("rst_dp_n",  32'(dp_n),  32'd1);
        chk("rst_an_n",  32'(an_n),  32'hF);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_levels();
        mdl_en = 1'b1;
        reset  = 1'b0;
        enable = 1'b1;

        // 0x1234 with dp on digit 1. The inputs change after the strobe, so they must be latched.
        load = 1'b1; value = 16'h1234; dp_in = 4'b0010;
        @(negedge clk);
        load = 1'b0; value = 16'($urandom); dp_in = 4'($urandom);
        check_frame(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0010);

        // Mid-frame load: digit 3 keeps the old glyph until the frame boundary.
        load = 1'b1; value = 16'hABCD; dp_in = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        chk("tear_an",  32'(an),  32'h8);
        chk("tear_seg", 32'(seg), 32'h06);
        check_frame(7'h5E, 7'h39, 7'h7C, 7'h77, 4'b0000);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        load = 1'b1; value = 16'h0050;
        @(negedge clk);
        load = 1'b0;
        check_frame(7'h3F, 7'h6D, 7'h00, 7'h00, 4'b0000);
        load = 1'b1; value = 16'h0000;
        @(negedge clk);
        load = 1'b0;
        check_frame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000);
        blank_lz = 1'b0;

        // Pause scanning for 10 cycles after the first cycle of slot 0.
        wait_fd();
        @(negedge clk);
        chk("pause_pre_an", 32'(an), 32'h1);
        enable = 1'b0;
        @(negedge clk);
        chk("pause_an",  32'(an),  32'h0);
        chk("pause_seg", 32'(seg), 32'h00);
        chk("pause_an_n", 32'(an_n), 32'hF);
        repeat (9) @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("resume_an", 32'(an), 32'h1);
        end
        @(negedge clk);
        chk("resume_next_an", 32'(an), 32'h2);

        // All segments lit: the active-low instance drives zeros.
        load = 1'b1; value = 16'h8888;
        @(negedge clk);
        load = 1'b0;
        check_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0000);

        // Reset mid-scan with a load pending. The pending load must be discarded.
        @(negedge clk);
        load = 1'b1; value = 16'h5555;
        @(negedge clk);
        load = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_levels();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_an",  32'(an),  32'h1);
        chk("post_rst_seg", 32'(seg), 32'h3F);
        wait_fd();
        @(negedge clk);
        chk("discard_seg", 32'(seg), 32'h3F);

        // Randomised traffic. The model compare checks every cycle.
        repeat (3000) begin
            @(negedge clk);
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            case ($urandom_range(0, 3))
                0: value = value & 16'h00FF;
                1: value = value & 16'h000F;
                2: value = 16'h0000;
                default: ;
            endcase
            dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
